// File: rtl/regfile_commit_sched.sv
// Commit scheduler: buffers ROB commits and drains one regfile write per cycle.
// Ports: ROB handshake in, regfile write/clear out, dispatcher stall + forwarding.
module regfile_commit_sched #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              rob_sched_valid_in,
  input  logic [REG_W-1:0]  rob_sched_d_in,
  input  logic [DATA_W-1:0] rob_sched_value_in,
  input  logic [ROB_W-1:0]  rob_sched_h_in,
  output logic              sched_rob_ready_out,
  input  logic              rob_sched_flush_in,
  output logic              sched_regfile_en_out,
  output logic [REG_W-1:0]  sched_regfile_d_out,
  output logic [DATA_W-1:0] sched_regfile_value_out,
  output logic [ROB_W-1:0]  sched_regfile_h_out,
  output logic              sched_regfile_rst_out,
  output logic              sched_dispatcher_stall_out,
  input  logic [REG_W-1:0]  dispatcher_sched_rs_in,
  input  logic [REG_W-1:0]  dispatcher_sched_rt_in,
  output logic              sched_dispatcher_rs_hit_out,
  output logic              sched_dispatcher_rt_hit_out,
  output logic [DATA_W-1:0] sched_dispatcher_rs_value_out,
  output logic [DATA_W-1:0] sched_dispatcher_rt_value_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rst_nxt;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [REG_W-1:0]  q_d [DEPTH];
  logic [DATA_W-1:0] q_v [DEPTH];
  logic [ROB_W-1:0]  q_h [DEPTH];

  logic push;
  logic pop;

  assign sched_rob_ready_out =
    rdy_in && (state == RUN) && (count < FULL);
  assign push = rob_sched_valid_in && sched_rob_ready_out;
  assign pop  = rdy_in && (count != '0);

  assign sched_dispatcher_stall_out = (state != RUN);

  always_comb begin
    state_nxt = state;
    rst_nxt   = 1'b0;
    unique case (state)
      RUN: begin
        if (rob_sched_flush_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Empty queue here means the pop stage is idle too.
        if (count == '0) begin
          state_nxt = CLEAR;
          rst_nxt   = 1'b1;
        end
      end
      CLEAR: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                   <= RUN;
      head                    <= '0;
      tail                    <= '0;
      count                   <= '0;
      sched_regfile_en_out    <= 1'b0;
      sched_regfile_d_out     <= '0;
      sched_regfile_value_out <= '0;
      sched_regfile_h_out     <= '0;
      sched_regfile_rst_out   <= 1'b0;
    end else if (rdy_in) begin
      state                 <= state_nxt;
      sched_regfile_rst_out <= rst_nxt;
      sched_regfile_en_out  <= pop;
      if (pop) begin
        sched_regfile_d_out     <= q_d[head];
        sched_regfile_value_out <= q_v[head];
        sched_regfile_h_out     <= q_h[head];
        head                    <= head + 1'b1;
      end
      if (push) tail <= tail + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_d[tail] <= rob_sched_d_in;
      q_v[tail] <= rob_sched_value_in;
      q_h[tail] <= rob_sched_h_in;
    end
  end

  // Walk oldest to youngest so the youngest match wins; the
  // output register is older than anything still queued.
  function automatic logic [DATA_W:0] lookup(
    input logic [REG_W-1:0] r
  );
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    idx = head;
    if (r != '0) begin
      if (sched_regfile_en_out && sched_regfile_d_out == r)
        res = {1'b1, sched_regfile_value_out};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + i[PW-1:0];
        if (i[PW:0] < count && q_d[idx] == r)
          res = {1'b1, q_v[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {sched_dispatcher_rs_hit_out, sched_dispatcher_rs_value_out} =
      lookup(dispatcher_sched_rs_in);
    {sched_dispatcher_rt_hit_out, sched_dispatcher_rt_value_out} =
      lookup(dispatcher_sched_rt_in);
  end

endmodule

// File: tb/tb_regfile_commit_sched.sv
// Bench for regfile_commit_sched: scoreboarded writes plus directed
// checks of backpressure, forwarding, flush sequencing and async reset.
module tb_regfile_commit_sched;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        valid;
  logic [4:0]  d;
  logic [31:0] v;
  logic [3:0]  h;
  logic        ready;
  logic        flush;
  logic        en;
  logic [4:0]  od;
  logic [31:0] ov;
  logic [3:0]  oh;
  logic        rf_rst;
  logic        stall;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  regfile_commit_sched dut (
    .clk_in                       (clk_in),
    .rst_n_in                     (rst_n_in),
    .rdy_in                       (rdy_in),
    .rob_sched_valid_in           (valid),
    .rob_sched_d_in               (d),
    .rob_sched_value_in           (v),
    .rob_sched_h_in               (h),
    .sched_rob_ready_out          (ready),
    .rob_sched_flush_in           (flush),
    .sched_regfile_en_out         (en),
    .sched_regfile_d_out          (od),
    .sched_regfile_value_out      (ov),
    .sched_regfile_h_out          (oh),
    .sched_regfile_rst_out        (rf_rst),
    .sched_dispatcher_stall_out   (stall),
    .dispatcher_sched_rs_in       (rs),
    .dispatcher_sched_rt_in       (rt),
    .sched_dispatcher_rs_hit_out  (rs_hit),
    .sched_dispatcher_rt_hit_out  (rt_hit),
    .sched_dispatcher_rs_value_out(rs_val),
    .sched_dispatcher_rt_value_out(rt_val)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [40:0] sb[$];
  logic        last_rdy = 1'b0;

  always @(posedge clk_in) begin
    last_rdy <= rdy_in;
    if (rst_n_in && valid && ready && rdy_in)
      sb.push_back({d, v, h});
  end

  always @(negedge clk_in) begin : mon
    logic [40:0] e;
    if (rst_n_in && en && last_rdy) begin
      if (sb.size() == 0) begin
        check("spurious_write", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("write", {23'd0, od, ov, oh}, {23'd0, e});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic offer(
    input logic [4:0]  dd,
    input logic [31:0] vv,
    input logic [3:0]  hh
  );
    valid = 1'b1;
    d     = dd;
    v     = vv;
    h     = hh;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    valid    = 1'b0;
    flush    = 1'b0;
    d = '0; v = '0; h = '0;
    rs = '0; rt = '0;
    cyc(2);
    check("rst_en", en, 0);
    check("rst_rf_rst", rf_rst, 0);
    check("rst_stall", stall, 0);
    check("rst_out_data", {od, ov, oh}, 0);
    rst_n_in = 1'b1;
    cyc();
    check("rst_ready", ready, 1);

    // single commit
    offer(5'd3, 32'h11, 4'd2);
    cyc();
    valid = 1'b0;
    check("single_e0", en, 0);
    cyc();
    check("single_e1", en, 1);
    cyc();
    check("single_once", en, 0);

    // backpressure / freeze
    rdy_in = 1'b0;
    offer(5'd7, 32'h77, 4'd7);
    cyc(2);
    check("bp_ready", ready, 0);
    check("bp_no_accept", sb.size(), 0);
    rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(5'(8 + i), 32'h100 + i, 4'(i));
      cyc();
      if (i == 1) begin
        rdy_in = 1'b0;
        cyc(2);
        check("freeze_en", en, 1);
        check("freeze_d", od, 8);
        check("freeze_ready", ready, 0);
        rdy_in = 1'b1;
      end
    end
    valid = 1'b0;
    cyc(3);
    check("bp_drained", sb.size(), 0);
    check("bp_ready_back", ready, 1);

    // forwarding
    offer(5'd5, 32'hA, 4'd1);
    cyc();
    offer(5'd5, 32'hB, 4'd2);
    rs = 5'd5;
    #1;
    check("fwd_excl_push", {rs_hit, rs_val}, {1'b1, 32'hA});
    cyc();
    valid  = 1'b0;
    rdy_in = 1'b0;
    rt     = 5'd5;
    #1;
    check("fwd_rs_young", {rs_hit, rs_val}, {1'b1, 32'hB});
    check("fwd_rt_young", {rt_hit, rt_val}, {1'b1, 32'hB});
    cyc();
    rs = 5'd0;
    rt = 5'd7;
    #1;
    check("fwd_rs_zero", rs_hit, 0);
    check("fwd_rt_miss", rt_hit, 0);
    rdy_in = 1'b1;
    cyc();
    rs = 5'd5;
    #1;
    check("fwd_outreg", {rs_hit, rs_val}, {1'b1, 32'hB});
    offer(5'd0, 32'h55, 4'd3);
    cyc();
    valid = 1'b0;
    cyc();
    rs = 5'd0;
    #1;
    check("fwd_d0_en", en, 1);
    check("fwd_d0_miss", rs_hit, 0);
    cyc(2);

    // flush with a burst in flight, repeat flushes ignored
    offer(5'd1, 32'hA1, 4'd1);
    cyc();
    offer(5'd2, 32'hA2, 4'd2);
    cyc();
    offer(5'd3, 32'hA3, 4'd3);
    flush = 1'b1;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("fl_en_%0d", k), en, k <= 2);
      check($sformatf("fl_rst_%0d", k), rf_rst, k == 3);
      check($sformatf("fl_stall_%0d", k), stall, k <= 3);
      check($sformatf("fl_ready_%0d", k), ready, k >= 4);
      valid = 1'b0;
      flush = (k <= 3);
      cyc();
    end
    flush = 1'b0;

    // flush with push on the same edge, empty queue
    offer(5'd12, 32'hC, 4'd3);
    flush = 1'b1;
    cyc();
    valid = 1'b0;
    flush = 1'b0;
    check("fp_stall", stall, 1);
    check("fp_en0", en, 0);
    cyc();
    check("fp_en1", en, 1);
    check("fp_rst1", rf_rst, 0);
    cyc();
    check("fp_rst2", rf_rst, 1);
    check("fp_en2", en, 0);
    cyc();
    check("fp_rst3", rf_rst, 0);
    check("fp_run", stall, 0);
    check("fp_ready", ready, 1);

    // async reset during DRAIN
    offer(5'd20, 32'h20, 4'd4);
    cyc();
    offer(5'd21, 32'h21, 4'd5);
    flush = 1'b1;
    cyc();
    valid = 1'b0;
    flush = 1'b0;
    check("ar_drain", stall, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("ar_en", en, 0);
    check("ar_rst", rf_rst, 0);
    check("ar_stall", stall, 0);
    check("ar_data", {od, ov, oh}, 0);
    sb.delete();
    cyc();
    rst_n_in = 1'b1;
    cyc(2);
    check("ar_ready", ready, 1);
    check("ar_run", stall, 0);
    check("ar_empty", en, 0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_commit_sched.md
# regfile_commit_sched

Commit scheduler between the reorder buffer and the register file's single write port. It accepts committed results from the ROB through a valid/ready handshake, buffers them in a small in-order queue, and drains exactly one write per cycle to the regfile. On a misprediction flush it finishes all already-committed writes first, then issues a one-cycle regfile rename-state clear while stalling the dispatcher. It also forwards queued-but-unwritten values to the dispatcher's two operand lookups.

## Interface
- REG_W, 5, register index width
- DATA_W, 32, data value width
- ROB_W, 4, ROB tag width
- DEPTH, 4, queue entries (power of two, ≥2)
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state and outputs
- rob_sched_valid_in  in  1  commit entry offered
- rob_sched_d_in / rob_sched_value_in / rob_sched_h_in  in  REG_W/DATA_W/ROB_W  dest reg, value, ROB tag
- sched_rob_ready_out  out  1  entry accepted at the edge when valid && ready
- rob_sched_flush_in  in  1  single-cycle flush request
- sched_regfile_en_out / _d_out / _value_out / _h_out  out  1/REG_W/DATA_W/ROB_W  registered write port
- sched_regfile_rst_out  out  1  registered rename-state clear pulse
- sched_dispatcher_stall_out  out  1  dispatcher must not issue
- dispatcher_sched_rs_in / _rt_in  in  REG_W  operand register indices
- sched_dispatcher_rs_hit_out / _rt_hit_out  out  1  pending write to that register exists
- sched_dispatcher_rs_value_out / _rt_value_out  out  DATA_W  youngest pending value

## Operation
- States: RUN, DRAIN, CLEAR. Reset → RUN, queue empty, all registered outputs 0.
- sched_rob_ready_out = rdy_in && state==RUN && count<DEPTH. Full queue deasserts ready even if a pop occurs the same cycle.
- Pop: each edge with rdy_in high and count>0 moves the head into the output register and sets en_out=1. With count==0, en_out=0. Push and pop can occur on the same edge.
- Entries with d=0 are queued and written like any other; the regfile ignores them.
- RUN: a flush sampled at an edge moves the state to DRAIN. A push accepted on that same edge is kept because it is an older commit.
- DRAIN: ready=0 and popping continues. At an edge where count==0, go to CLEAR; on that edge en_out←0 and rst_out←1.
- CLEAR: lasts one cycle, then RUN, with rst_out←0.
- rst_out and en_out are never high in the same cycle.
- Flushes sampled while in DRAIN or CLEAR are ignored.
- stall_out = (state != RUN), combinational.
- Lookup (combinational):
  - The candidates are the valid queue entries plus the output register when en_out=1.
  - A hit needs a matching d and a nonzero index.
  - The value returned is from the youngest matching candidate: queue tail toward head, then the output register.
  - The entry being pushed in the current cycle is excluded.
- Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- Accept at edge E on an empty queue → en_out high during cycle E+1 (1-cycle latency). The regfile writes at edge E+2.
- Sustained throughput: 1 write per cycle.
- Flush sampled at edge F with N entries left after F's pop:
  - en_out stays high for cycles F+1 … F+N.
  - rst_out is high for the single cycle after edge F+N+1.
  - RUN resumes after edge F+N+2.
  - stall_out is high from after F through the CLEAR cycle.
- Empty-queue flush: CLEAR after edge F+1, RUN after F+2.
- rdy_in low: queue, state and output registers hold. en_out/rst_out keep their values. No push is accepted.
- Async reset mid-operation: the queue empties immediately, state goes to RUN, and every output register goes to 0, independent of the clock.

## Test plan
- Single commit: push (d=3, value=0x11, h=2) into an empty queue at E → en_out=1, d=3, value=0x11, h=2 in cycle E+1 only.
- Fill/backpressure (DEPTH=4): with pops suppressed by holding rdy_in low after 4 pushes, ready stays 0. After rdy_in rises, 4 consecutive en_out cycles appear in push order, and ready returns to 1.
- Forwarding: queue holds d=5 (0xA) then d=5 (0xB) → rs_in=5 gives hit=1, value=0xB. rs_in=0 gives hit=0. A register present only in the output register still hits.
- Flush with 3 pending:
  - writes appear in 3 cycles, then exactly one rst_out cycle with en_out=0;
  - stall_out is high throughout;
  - ready is 0 until RUN;
  - a second flush during DRAIN has no effect.
- Flush with push on the same edge and an empty queue: the pushed entry is written, then rst_out fires, then RUN.
- Async reset asserted during DRAIN with 2 entries: all outputs read 0 immediately. After release, state is RUN and ready=1.
